// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: state codes, opcode/funct values,
// datapath select codes and the decoder's class flags. Optional MDU support: MC_CTRL_MDU_EN.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_DCD = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
`ifdef MC_CTRL_MDU_EN
    , S_MDU = 3'd5
`endif
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_MFHI = 6'h10;
  localparam logic [5:0] F_MFLO = 6'h12;
  localparam logic [5:0] F_MULT = 6'h18;
  localparam logic [5:0] F_DIV  = 6'h1A;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUBU = 6'h23;

  localparam logic [2:0] NPC_PC4 = 3'd0;
  localparam logic [2:0] NPC_J26 = 3'd1;
  localparam logic [2:0] NPC_JR  = 3'd2;
  localparam logic [2:0] NPC_B16 = 3'd3;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_OR  = 4'd2;
  localparam logic [3:0] ALU_SLL = 4'd3;

  localparam logic [2:0] EXT_ZERO = 3'd0;
  localparam logic [2:0] EXT_SIGN = 3'd1;
  localparam logic [2:0] EXT_LUI  = 3'd2;

  localparam logic [2:0] DM_WORD = 3'd0;

  localparam logic [2:0] B_RT  = 3'd0;
  localparam logic [2:0] B_EXT = 3'd1;

  localparam logic [2:0] A3_RD = 3'd0;
  localparam logic [2:0] A3_RT = 3'd1;
  localparam logic [2:0] A3_31 = 3'd2;

  localparam logic [2:0] WD_ALU = 3'd0;
  localparam logic [2:0] WD_DM  = 3'd1;
  localparam logic [2:0] WD_PC4 = 3'd2;
  localparam logic [2:0] WD_EXT = 3'd3;
  localparam logic [2:0] WD_MDU = 3'd4;

  typedef struct packed {
    logic calr;
    logic cali;
    logic load;
    logic store;
    logic branch;
    logic jump;
    logic jal;
    logic jr;
    logic illegal;
    logic mdu;
  } inst_class_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: opcode/funct to class flags.
// MDU functs are recognised only when MC_CTRL_MDU_EN is defined.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  output inst_class_t cls
);

  always_comb begin
    cls = '0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          F_SLL, F_ADDU, F_SUBU: cls.calr = 1'b1;
          F_JR: begin
            cls.jr   = 1'b1;
            cls.jump = 1'b1;
          end
`ifdef MC_CTRL_MDU_EN
          F_MULT, F_DIV, F_MFHI, F_MFLO: cls.mdu = 1'b1;
`endif
          default: cls.illegal = 1'b1;
        endcase
      end
      OP_ORI, OP_LUI: cls.cali   = 1'b1;
      OP_LW:          cls.load   = 1'b1;
      OP_SW:          cls.store  = 1'b1;
      OP_BEQ:         cls.branch = 1'b1;
      OP_J:           cls.jump   = 1'b1;
      OP_JAL: begin
        cls.jump = 1'b1;
        cls.jal  = 1'b1;
      end
      default: cls.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle sequencing controller (IF/DCD/EXE/MEM/WB) with a stallable shared memory port
// and optional wait timeout. Define MC_CTRL_MDU_EN to add the S_MDU state and MDU handshake.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int IM_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic        cmp,
  input  logic        mem_ready,
`ifdef MC_CTRL_MDU_EN
  input  logic        mdu_busy,
  output logic        mdu_start,
`endif
  output logic        mem_req,
  output logic        PC_wr,
  output logic        IR_wr,
  output logic        RF_wr,
  output logic        DM_wr,
  output logic [2:0]  NPC_op,
  output logic [2:0]  EXT_op,
  output logic [2:0]  DM_op,
  output logic [2:0]  RF_A3_sel,
  output logic [2:0]  RF_WD_sel,
  output logic [2:0]  ALU_B_sel,
  output logic [3:0]  ALU_op,
  output logic [2:0]  state,
  output logic        illegal,
  output logic        timeout
);

  localparam int CNT_W = 16;

  state_t             cur;
  inst_class_t        cls;
  logic [CNT_W-1:0]   wait_cnt;
  logic               in_wait_state;
  logic               waiting;
  logic               tmo_hit;
  logic [5:0]         funct;

  assign funct = Instr[5:0];

  mc_decode u_decode (
    .op    (Instr[31:26]),
    .funct (funct),
    .cls   (cls)
  );

  assign in_wait_state = (cur == S_IF) || (cur == S_MEM);
  assign waiting       = in_wait_state && !mem_ready;
  // A ready in the limit cycle completes the transfer instead of timing out.
  assign tmo_hit       = (IM_TIMEOUT != 0) && waiting && (wait_cnt == CNT_W'(IM_TIMEOUT));

`ifdef MC_CTRL_MDU_EN
  logic is_mf;
  assign is_mf = (funct == F_MFHI) || (funct == F_MFLO);
  logic unused_bits;
  assign unused_bits = ^Instr[25:6];
`else
  logic unused_bits;
  assign unused_bits = ^{Instr[25:6], cls.mdu};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur      <= S_IF;
      wait_cnt <= '0;
    end else begin
      if (waiting && !tmo_hit && (IM_TIMEOUT != 0)) wait_cnt <= wait_cnt + 1'b1;
      else                                          wait_cnt <= '0;

      case (cur)
        S_IF:  if (mem_ready) cur <= S_DCD;
        S_DCD: cur <= (cls.jump || cls.illegal) ? S_IF : S_EXE;
        S_EXE: begin
          if (cls.load || cls.store)     cur <= S_MEM;
          else if (cls.calr || cls.cali) cur <= S_WB;
`ifdef MC_CTRL_MDU_EN
          else if (cls.mdu)              cur <= S_MDU;
`endif
          else                           cur <= S_IF;
        end
        S_MEM: begin
          if (mem_ready)    cur <= cls.load ? S_WB : S_IF;
          else if (tmo_hit) cur <= S_IF;
        end
        S_WB:  cur <= S_IF;
`ifdef MC_CTRL_MDU_EN
        S_MDU: if (!mdu_busy) cur <= is_mf ? S_WB : S_IF;
`endif
        default: cur <= S_IF;
      endcase
    end
  end

  assign state = cur;
  assign DM_op = DM_WORD;

  // Selects follow the instruction; strobes follow the state and are masked by reset.
  always_comb begin
    mem_req   = 1'b0;
    PC_wr     = 1'b0;
    IR_wr     = 1'b0;
    RF_wr     = 1'b0;
    DM_wr     = 1'b0;
    illegal   = 1'b0;
    timeout   = 1'b0;
`ifdef MC_CTRL_MDU_EN
    mdu_start = 1'b0;
`endif
    ALU_op    = ALU_ADD;
    ALU_B_sel = B_RT;
    EXT_op    = EXT_ZERO;
    RF_A3_sel = (cls.calr || cls.mdu) ? A3_RD : A3_RT;
    RF_WD_sel = WD_ALU;
    NPC_op    = NPC_PC4;

    if (cls.calr) begin
      if (funct == F_SUBU)     ALU_op = ALU_SUB;
      else if (funct == F_SLL) ALU_op = ALU_SLL;
    end
    if (cls.cali || cls.load || cls.store) ALU_B_sel = B_EXT;
    if (cls.cali && Instr[31:26] == OP_ORI) ALU_op = ALU_OR;
    if (cls.branch) ALU_op = ALU_SUB;
    if (cls.load || cls.store || cls.branch) EXT_op = EXT_SIGN;
    if (cls.cali && Instr[31:26] == OP_LUI) begin
      EXT_op    = EXT_LUI;
      RF_WD_sel = WD_EXT;
    end
    if (cls.load) RF_WD_sel = WD_DM;
`ifdef MC_CTRL_MDU_EN
    if (cls.mdu) RF_WD_sel = WD_MDU;
`endif
    if (cls.jal) begin
      RF_A3_sel = A3_31;
      RF_WD_sel = WD_PC4;
    end
    if (cur != S_IF) begin
      if (cls.jr)          NPC_op = NPC_JR;
      else if (cls.jump)   NPC_op = NPC_J26;
      else if (cls.branch) NPC_op = NPC_B16;
    end

    case (cur)
      S_IF: begin
        mem_req = 1'b1;
        IR_wr   = mem_ready;
        PC_wr   = mem_ready;
        timeout = tmo_hit;
      end
      S_DCD: begin
        illegal = cls.illegal;
        PC_wr   = cls.jump;
        RF_wr   = cls.jal;
      end
      S_EXE: begin
        PC_wr = cls.branch && cmp;
`ifdef MC_CTRL_MDU_EN
        mdu_start = cls.mdu;
`endif
      end
      S_MEM: begin
        mem_req = 1'b1;
        DM_wr   = cls.store && !tmo_hit;
        timeout = tmo_hit;
      end
      S_WB:  RF_wr = 1'b1;
      default: ;
    endcase

    if (!reset) begin
      mem_req = 1'b0;
      PC_wr   = 1'b0;
      IR_wr   = 1'b0;
      RF_wr   = 1'b0;
      DM_wr   = 1'b0;
      illegal = 1'b0;
      timeout = 1'b0;
`ifdef MC_CTRL_MDU_EN
      mdu_start = 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl with IM_TIMEOUT=4: state sequences, strobes and selects
// per instruction class, stalls, mid-instruction reset and wait timeout.
module tb_mc_ctrl;
  import mc_ctrl_pkg::*;

  localparam logic [31:0] I_ADDU = 32'h0022_1821;
  localparam logic [31:0] I_LW   = 32'h8C25_0004;
  localparam logic [31:0] I_SW   = 32'hAC25_0008;
  localparam logic [31:0] I_BEQ  = 32'h1022_0003;
  localparam logic [31:0] I_JAL  = 32'h0C00_0010;
  localparam logic [31:0] I_J    = 32'h0800_0010;
  localparam logic [31:0] I_JR   = 32'h03E0_0008;
  localparam logic [31:0] I_ORI  = 32'h3424_00FF;
  localparam logic [31:0] I_LUI  = 32'h3C04_1234;
  localparam logic [31:0] I_NOP  = 32'h0000_0000;
  localparam logic [31:0] I_MULT = 32'h0022_0018;
  localparam logic [31:0] I_BAD  = 32'hFC00_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instr;
  logic        cmp;
  logic        mem_ready;
  logic        mem_req, PC_wr, IR_wr, RF_wr, DM_wr, illegal, timeout;
  logic [2:0]  NPC_op, EXT_op, DM_op, RF_A3_sel, RF_WD_sel, ALU_B_sel, state;
  logic [3:0]  ALU_op;
  logic [6:0]  strb;
`ifdef MC_CTRL_MDU_EN
  logic        mdu_busy = 1'b0;
  logic        mdu_start;
`endif

  int checks = 0;
  int errors = 0;

  mc_ctrl #(.IM_TIMEOUT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .Instr     (Instr),
    .cmp       (cmp),
    .mem_ready (mem_ready),
`ifdef MC_CTRL_MDU_EN
    .mdu_busy  (mdu_busy),
    .mdu_start (mdu_start),
`endif
    .mem_req   (mem_req),
    .PC_wr     (PC_wr),
    .IR_wr     (IR_wr),
    .RF_wr     (RF_wr),
    .DM_wr     (DM_wr),
    .NPC_op    (NPC_op),
    .EXT_op    (EXT_op),
    .DM_op     (DM_op),
    .RF_A3_sel (RF_A3_sel),
    .RF_WD_sel (RF_WD_sel),
    .ALU_B_sel (ALU_B_sel),
    .ALU_op    (ALU_op),
    .state     (state),
    .illegal   (illegal),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  // {mem_req, PC_wr, IR_wr, RF_wr, DM_wr, illegal, timeout}
  assign strb = {mem_req, PC_wr, IR_wr, RF_wr, DM_wr, illegal, timeout};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input string tag, input logic [2:0] es, input logic [6:0] ex);
    @(negedge clk);
    chk({tag, ".state"}, 32'(state), 32'(es));
    chk({tag, ".strb"}, 32'(strb), 32'(ex));
  endtask

  task automatic step(input string tag, input logic [2:0] es, input logic [6:0] ex);
    cyc(tag, es, ex);
    nxt();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; Instr = I_NOP; cmp = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cyc("rst", S_IF, 7'h00);
    nxt();
    reset = 1'b1;

    Instr = I_ADDU;
    cyc("addu.if", S_IF, 7'h70);
    chk("addu.if.npc", 32'(NPC_op), 32'(NPC_PC4));
    nxt();
    step("addu.dcd", S_DCD, 7'h00);
    cyc("addu.exe", S_EXE, 7'h00);
    chk("addu.exe.alu", 32'(ALU_op), 32'(ALU_ADD));
    chk("addu.exe.bsel", 32'(ALU_B_sel), 32'(B_RT));
    nxt();
    cyc("addu.wb", S_WB, 7'h08);
    chk("addu.wb.a3", 32'(RF_A3_sel), 32'(A3_RD));
    chk("addu.wb.wd", 32'(RF_WD_sel), 32'(WD_ALU));
    nxt();

    Instr = I_LW;
    step("lw.if", S_IF, 7'h70);
    step("lw.dcd", S_DCD, 7'h00);
    cyc("lw.exe", S_EXE, 7'h00);
    chk("lw.exe.alu", 32'(ALU_op), 32'(ALU_ADD));
    chk("lw.exe.bsel", 32'(ALU_B_sel), 32'(B_EXT));
    chk("lw.exe.ext", 32'(EXT_op), 32'(EXT_SIGN));
    nxt();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("lw.mem_wait", S_MEM, 7'h40);
    mem_ready = 1'b1;
    step("lw.mem_done", S_MEM, 7'h40);
    cyc("lw.wb", S_WB, 7'h08);
    chk("lw.wb.wd", 32'(RF_WD_sel), 32'(WD_DM));
    chk("lw.wb.a3", 32'(RF_A3_sel), 32'(A3_RT));
    nxt();

    Instr = I_BEQ; cmp = 1'b1;
    step("beq1.if", S_IF, 7'h70);
    step("beq1.dcd", S_DCD, 7'h00);
    cyc("beq1.exe", S_EXE, 7'h20);
    chk("beq1.exe.npc", 32'(NPC_op), 32'(NPC_B16));
    nxt();
    cmp = 1'b0;
    step("beq0.if", S_IF, 7'h70);
    step("beq0.dcd", S_DCD, 7'h00);
    step("beq0.exe", S_EXE, 7'h00);

    Instr = I_JAL;
    step("jal.if", S_IF, 7'h70);
    cyc("jal.dcd", S_DCD, 7'h28);
    chk("jal.dcd.npc", 32'(NPC_op), 32'(NPC_J26));
    chk("jal.dcd.a3", 32'(RF_A3_sel), 32'(A3_31));
    chk("jal.dcd.wd", 32'(RF_WD_sel), 32'(WD_PC4));
    nxt();

    Instr = I_J;
    step("j.if", S_IF, 7'h70);
    cyc("j.dcd", S_DCD, 7'h20);
    chk("j.dcd.npc", 32'(NPC_op), 32'(NPC_J26));
    nxt();

    Instr = I_JR;
    step("jr.if", S_IF, 7'h70);
    cyc("jr.dcd", S_DCD, 7'h20);
    chk("jr.dcd.npc", 32'(NPC_op), 32'(NPC_JR));
    nxt();

    Instr = I_ORI;
    step("ori.if", S_IF, 7'h70);
    step("ori.dcd", S_DCD, 7'h00);
    cyc("ori.exe", S_EXE, 7'h00);
    chk("ori.exe.alu", 32'(ALU_op), 32'(ALU_OR));
    chk("ori.exe.bsel", 32'(ALU_B_sel), 32'(B_EXT));
    chk("ori.exe.ext", 32'(EXT_op), 32'(EXT_ZERO));
    nxt();
    cyc("ori.wb", S_WB, 7'h08);
    chk("ori.wb.a3", 32'(RF_A3_sel), 32'(A3_RT));
    chk("ori.wb.wd", 32'(RF_WD_sel), 32'(WD_ALU));
    nxt();

    Instr = I_LUI;
    step("lui.if", S_IF, 7'h70);
    step("lui.dcd", S_DCD, 7'h00);
    cyc("lui.exe", S_EXE, 7'h00);
    chk("lui.exe.ext", 32'(EXT_op), 32'(EXT_LUI));
    nxt();
    cyc("lui.wb", S_WB, 7'h08);
    chk("lui.wb.wd", 32'(RF_WD_sel), 32'(WD_EXT));
    chk("lui.wb.a3", 32'(RF_A3_sel), 32'(A3_RT));
    nxt();

    Instr = I_NOP;
    step("nop.if", S_IF, 7'h70);
    step("nop.dcd", S_DCD, 7'h00);
    cyc("nop.exe", S_EXE, 7'h00);
    chk("nop.exe.alu", 32'(ALU_op), 32'(ALU_SLL));
    nxt();
    step("nop.wb", S_WB, 7'h08);

`ifndef MC_CTRL_MDU_EN
    Instr = I_MULT;
    step("mult.if", S_IF, 7'h70);
    step("mult.dcd", S_DCD, 7'h02);
`endif

    Instr = I_BAD;
    step("bad.if", S_IF, 7'h70);
    step("bad.dcd", S_DCD, 7'h02);

    Instr = I_SW;
    step("sw.if", S_IF, 7'h70);
    step("sw.dcd", S_DCD, 7'h00);
    step("sw.exe", S_EXE, 7'h00);
    mem_ready = 1'b0;
    step("sw.mem_wait", S_MEM, 7'h44);
    cyc("sw.mem", S_MEM, 7'h44);
    reset = 1'b0;
    #1;
    chk("sw.rst.dm_wr", 32'(DM_wr), 32'd0);
    chk("sw.rst.state", 32'(state), 32'(S_IF));
    chk("sw.rst.strb", 32'(strb), 32'd0);
    nxt();
    reset = 1'b1;

    for (int i = 0; i < 4; i++) step("tmo.wait", S_IF, 7'h40);
    step("tmo.pulse", S_IF, 7'h41);
    for (int i = 0; i < 4; i++) step("tmo.rewait", S_IF, 7'h40);
    mem_ready = 1'b1;
    step("tmo.ready_wins", S_IF, 7'h70);
    step("sw2.dcd", S_DCD, 7'h00);
    step("sw2.exe", S_EXE, 7'h00);
    step("sw2.mem", S_MEM, 7'h44);
    cyc("sw2.next_if", S_IF, 7'h70);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle sequencing controller for the MIPS datapath (IFU, NPC, RF, ALU, EXT, DM). It replaces the single-cycle combinational control path with a Moore-style FSM. The FSM steps each instruction through fetch, decode, execute, memory and write-back. It issues one-cycle write strobes per state and handshakes with a shared instruction/data memory port that may stall.

## Interface
Parameters:
- `IM_TIMEOUT`, default 0: when non-zero, the maximum number of cycles spent waiting in `S_IF` or `S_MEM` before `timeout` is pulsed and the FSM returns to `S_IF`. A value of 0 means wait forever.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `Instr`  in  32  current instruction from the IR; decoded in `S_DCD` and later states.
- `cmp`  in  1  ALU compare result (equal) for `beq`.
- `mem_ready`  in  1  memory port completion for the current request.
- `mem_req`  out  1  memory request; high throughout `S_IF` and `S_MEM`.
- `PC_wr`, `IR_wr`, `RF_wr`, `DM_wr`  out  1 each  datapath write strobes.
- `NPC_op`, `EXT_op`, `DM_op`, `RF_A3_sel`, `RF_WD_sel`, `ALU_B_sel`  out  3 each  datapath selects; codes come from `const.v`.
- `ALU_op`  out  4  ALU operation code.
- `state`  out  3  current FSM state, for debug and bench observation.
- `illegal`  out  1  one-cycle pulse when an unknown opcode or funct is decoded.
- `timeout`  out  1  one-cycle pulse when the memory wait is abandoned.

## Operation
States: `S_IF`, `S_DCD`, `S_EXE`, `S_MEM`, `S_WB`, plus `S_MDU` when it is configured in.

`S_IF`:
- `mem_req`=1.
- On `mem_ready`: `IR_wr`=1, `PC_wr`=1 with `NPC_op`=PC4, then go to `S_DCD`.
- Otherwise stay in `S_IF`.

`S_DCD`:
- `j`: `PC_wr` with `NPC_op`=J26, then `S_IF`.
- `jr`: `PC_wr` with `NPC_op`=JR, then `S_IF`.
- `jal`: `PC_wr` with `NPC_op`=J26, plus `RF_wr`, `RF_A3_sel`=31 and `RF_WD_sel`=PC4, all in the same cycle; then `S_IF`.
- Unknown opcode or funct: `illegal` pulse, no write strobes, then `S_IF`.
- Everything else goes to `S_EXE`.

`S_EXE`:
- `ALU_op`, `ALU_B_sel` and `EXT_op` are driven per instruction.
- `beq`: `PC_wr`=`cmp` with `NPC_op`=B16, then `S_IF`.
- `lw` and `sw` go to `S_MEM`.
- `addu`, `subu`, `ori`, `lui` and `sll` go to `S_WB`.

`S_MEM`:
- `mem_req`=1.
- `sw`: `DM_wr`=1 throughout the state; on `mem_ready` go to `S_IF`.
- `lw`: on `mem_ready` go to `S_WB`.

`S_WB`:
- `RF_wr`=1 for exactly one cycle.
- `RF_A3_sel` is rd for R-type, rt for I-type.
- `RF_WD_sel` is ALU for calculation instructions, DM for `lw`, EXT for `lui`.
- Then `S_IF`.

General rules:
- Select outputs are combinational from `state` and `Instr`. Their values are don't-care whenever no strobe consumes them; the bench must not check them then.
- `nop` (all-zero instruction) is `sll $0`. It passes through `S_WB` and writes `$0`, which the RF discards.

## Timing
- Reset: while `reset`=0, the state register is `S_IF` and all strobes are 0.
  - Strobes are masked, including `mem_req`, `illegal` and `timeout`.
  - The wait counter is 0.
- First `mem_req` is in the first cycle after `reset` rises.
- Reset asserted mid-instruction (for example in `S_MEM` of `sw`): `DM_wr` drops combinationally. No partial write is promised beyond that cycle.
- Latency with zero memory wait:
  - j, jr, jal: 2 cycles.
  - beq: 3 cycles.
  - R-type, ori, lui, sw: 4 cycles.
  - lw: 5 cycles.
  - Each cycle `mem_ready` is held low adds 1 cycle.
- Handshake:
  - A transfer completes in the cycle where `mem_req` and `mem_ready` are both 1.
  - `mem_ready` outside `S_IF` and `S_MEM` is ignored.
- Timeout (`IM_TIMEOUT`>0):
  - The wait counter increments on each waiting cycle and clears when the state changes.
  - When the counter reaches `IM_TIMEOUT`: `timeout` pulses, no strobe is issued, the next state is `S_IF` and PC is unchanged.
  - If `mem_ready` arrives in the same cycle as the timeout, `mem_ready` wins.

## Configuration
- Macro: `MC_CTRL_MDU_EN`.
- Defined:
  - `mult`, `div`, `mfhi` and `mflo` are decoded.
  - In `S_EXE`, `mdu_start` (extra 1-bit output) pulses, then the FSM enters `S_MDU`.
  - The FSM stays in `S_MDU` while `mdu_busy` (extra 1-bit input) is 1.
  - On exit from `S_MDU`, `mfhi` and `mflo` go to `S_WB` with `RF_WD_sel`=MDU; `mult` and `div` go to `S_IF`.
- Undefined:
  - The MDU ports and `S_MDU` are absent.
  - These functs raise `illegal`.

## Structure
- Shared definitions go in `const.v`:
  - State encodings `S_*`.
  - Opcode and funct constants.
  - All `NPC_op`, `ALU_op`, `EXT_op`, `DM_op` and selector codes.
- One sub-module, `mc_decode`: a combinational classifier mapping `Instr` to instruction-class flags (calr, cali, load, store, branch, jump, jal, jr, illegal, mdu).
- The FSM and the timeout counter stay in `mc_ctrl`.

## Test plan
- `addu` with `mem_ready`=1: states go `S_IF`→`S_DCD`→`S_EXE`→`S_WB`; `RF_wr`=1 only in `S_WB`, with A3 sel=rd; 4 cycles.
- `lw` with `mem_ready` low for 3 cycles in `S_MEM`: the FSM stays in `S_MEM` for 4 cycles, then `RF_wr` pulses once with WD sel=DM; 8 cycles total.
- `beq` with `cmp`=1, then `cmp`=0: `PC_wr`=1 with `NPC_op`=B16 in `S_EXE` for the first only; 3 cycles each.
- `jal`: in `S_DCD`, `PC_wr`=1, `RF_wr`=1, A3 sel=31 and WD sel=PC4, all together; then `S_IF`.
- `reset`=0 during `S_MEM` of `sw`: `DM_wr` goes to 0 at once; after release, the FSM is in `S_IF` with `mem_req`=1 the next cycle.
- Opcode 6'h3F: `illegal` pulses in `S_DCD` with no strobes. With `IM_TIMEOUT`=4 and `mem_ready` held at 0: `timeout` pulses after 4 cycles in `S_IF`, and PC is never written.
